// File: rtl/spi_deserializer_if.sv
// Receive-FIFO write port: the deserializer pushes words, the FIFO reports full.
interface spi_deserializer_if #(
  parameter int DATAWIDTH = 32
);
  logic                 writeEn;
  logic [DATAWIDTH-1:0] writeData;
  logic                 full;

  modport master (output writeEn, output writeData, input full);
  modport slave  (input writeEn, input writeData, output full);
endinterface

// File: rtl/spi_deserializer.sv
// SPI receive side: synchronizes sclk/mosi/ss_n into clk, shifts MSB-first words
// on sclk rising edges and pushes each completed word into the receive FIFO.
module spi_deserializer #(
  parameter int DATAWIDTH       = 32,
  parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  spi_deserializer_if.master    fifo,
  output logic                  done,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  localparam logic [BITCOUNTERWIDTH-1:0] LAST_BIT = BITCOUNTERWIDTH'(DATAWIDTH - 1);
  localparam logic [BITCOUNTERWIDTH-1:0] CNT_ONE  = BITCOUNTERWIDTH'(1);

  state_t                     state, state_nxt;
  logic                       sclk_m, sclk_s, sclk_d;
  logic                       mosi_m, mosi_s;
  logic                       ss_m, ss_s;
  logic                       sclk_rise;
  logic [DATAWIDTH-1:0]       shift_reg;
  logic [DATAWIDTH-1:0]       write_data_q;
  logic [BITCOUNTERWIDTH-1:0] bit_cnt;
  logic                       frame_err_q;
  logic                       clr_word, shift_en, last_bit, frame_err_nxt;

  // Input synchronizers; sclk gets an extra flop for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
      ss_m   <= 1'b1;
      ss_s   <= 1'b1;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
      ss_m   <= ss_n;
      ss_s   <= ss_m;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    clr_word      = 1'b0;
    shift_en      = 1'b0;
    last_bit      = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s) begin
          state_nxt = SHIFT;
          clr_word  = 1'b1;
        end
      end
      SHIFT: begin
        // A completing edge wins over a simultaneous ss_n deassertion
        if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            last_bit  = 1'b1;
            state_nxt = PUSH;
          end
        end else if (ss_s) begin
          state_nxt     = IDLE;
          frame_err_nxt = (bit_cnt != '0);
        end
      end
      PUSH:    state_nxt = ss_s ? IDLE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // Word assembly; writeData is captured with the final bit and held until the next word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      write_data_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_err_nxt;
      if (clr_word) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[DATAWIDTH-2:0], mosi_s};
        bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_ONE;
        if (last_bit) write_data_q <= {shift_reg[DATAWIDTH-2:0], mosi_s};
      end
    end
  end

  assign fifo.writeEn   = (state == PUSH) & ~fifo.full;
  assign fifo.writeData = write_data_q;
  assign done           = (state == PUSH) & ~fifo.full;
  assign overrun        = (state == PUSH) &  fifo.full;
  assign frame_err      = frame_err_q;
  assign busy           = (state != IDLE);

endmodule
